// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: stall codes, bus widths, opcodes, FSM states, immediate helpers.
// No logic of its own.
// Imported by inst_fetch and inst_predecode.
package inst_fetch_pkg;

    typedef logic [1:0]  StallBus;
    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    localparam StallBus Pass = 2'd0;
    localparam StallBus Hold = 2'd1;
    localparam StallBus Bubb = 2'd2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_WAIT    = 2'd1,
        IF_READY   = 2'd2,
        IF_DISCARD = 2'd3
    } if_state_e;

    function automatic InstAddrBus j_imm(input InstBus inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic InstAddrBus b_imm(input InstBus inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_predecode.sv
// Static branch predictor on the fetched word; taken only for JAL and backward branches (STATIC_PREDICT_EN).
// Latency: combinational.
// Backpressure: none, pure function of inst and pc.
module inst_predecode
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        predict_result,
    output logic [31:0] next_pc
);

`ifdef STATIC_PREDICT_EN
    always_comb begin
        predict_result = 1'b0;
        next_pc        = pc + 32'd4;
        if (inst[6:0] == OP_JAL) begin
            predict_result = 1'b1;
            next_pc        = pc + j_imm(inst);
        end else if (inst[6:0] == OP_BRANCH && inst[31]) begin
            // sign bit of the B-immediate marks a backward (loop) branch
            predict_result = 1'b1;
            next_pc        = pc + b_imm(inst);
        end
    end
`else
    logic unused_inst;

    assign unused_inst    = ^inst;
    assign predict_result = 1'b0;
    assign next_pc        = pc + 32'd4;
`endif

endmodule

// File: rtl/inst_fetch.sv
// Fetch PC holder and IF/ID producer; one outstanding word request, redirect on branch_error (predictor: STATIC_PREDICT_EN).
// Latency: instruction valid the cycle after inst_ready_i; N+2 cycles per instruction back to back.
// Backpressure: stall Hold/Bubb freezes the presented instruction; in-flight fetches always run to completion.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall,
    input  logic        branch_error,
    input  logic [31:0] branch_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i,
    input  logic [31:0] inst_data_i,
    output logic        stall_req_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] next_pc_o,
    output logic        predict_result_o
);

    if_state_e  state, state_nxt;
    InstAddrBus pc_r, pc_nxt;
    logic       req_nxt, stall_req_nxt, pred_nxt;
    InstAddrBus addr_nxt, pc_o_nxt, next_pc_nxt;
    InstBus     inst_nxt;

    logic       pd_pred;
    InstAddrBus pd_next_pc;

    // A transaction is still open at the memory controller and must be drained.
    logic       in_flight;

    assign in_flight = (state == IF_WAIT || state == IF_DISCARD) && !inst_ready_i;

    inst_predecode u_predecode (
        .pc             (pc_r),
        .inst           (inst_data_i),
        .predict_result (pd_pred),
        .next_pc        (pd_next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IF_IDLE;
            pc_r             <= RESET_PC;
            inst_req_o       <= 1'b0;
            inst_addr_o      <= 32'h0;
            stall_req_o      <= 1'b1;
            pc_o             <= 32'h0;
            inst_o           <= 32'h0;
            next_pc_o        <= 32'h0;
            predict_result_o <= 1'b0;
        end else begin
            state            <= state_nxt;
            pc_r             <= pc_nxt;
            inst_req_o       <= req_nxt;
            inst_addr_o      <= addr_nxt;
            stall_req_o      <= stall_req_nxt;
            pc_o             <= pc_o_nxt;
            inst_o           <= inst_nxt;
            next_pc_o        <= next_pc_nxt;
            predict_result_o <= pred_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (branch_error) begin
            state_nxt = in_flight ? IF_DISCARD : IF_WAIT;
        end else begin
            case (state)
                IF_IDLE:    state_nxt = IF_WAIT;
                IF_WAIT:    if (inst_ready_i) state_nxt = IF_READY;
                IF_READY:   if (stall == Pass) state_nxt = IF_WAIT;
                IF_DISCARD: if (inst_ready_i) state_nxt = IF_WAIT;
                default:    state_nxt = IF_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_nxt        = pc_r;
        req_nxt       = inst_req_o;
        addr_nxt      = inst_addr_o;
        stall_req_nxt = stall_req_o;
        pc_o_nxt      = pc_o;
        inst_nxt      = inst_o;
        next_pc_nxt   = next_pc_o;
        pred_nxt      = predict_result_o;
        if (branch_error) begin
            // An open transaction keeps its old address; the redirect is issued once it drains.
            pc_nxt        = branch_pc_i;
            stall_req_nxt = 1'b1;
            req_nxt       = 1'b1;
            if (!in_flight) addr_nxt = branch_pc_i;
        end else begin
            case (state)
                IF_IDLE: begin
                    req_nxt  = 1'b1;
                    addr_nxt = pc_r;
                end
                IF_WAIT: begin
                    if (inst_ready_i) begin
                        inst_nxt      = inst_data_i;
                        pc_o_nxt      = pc_r;
                        next_pc_nxt   = pd_next_pc;
                        pred_nxt      = pd_pred;
                        req_nxt       = 1'b0;
                        stall_req_nxt = 1'b0;
                    end
                end
                IF_READY: begin
                    // Hold and Bubb both keep the instruction presented.
                    if (stall == Pass) begin
                        pc_nxt        = next_pc_o;
                        req_nxt       = 1'b1;
                        addr_nxt      = next_pc_o;
                        stall_req_nxt = 1'b1;
                    end
                end
                IF_DISCARD: begin
                    if (inst_ready_i) addr_nxt = pc_r;
                end
                default: ;
            endcase
        end
    end

endmodule
